// File: rtl/matmul_index_gen.sv
// matmul_index_gen: walks the i/j/k loop nest of C = A*B (k innermost) and emits one tuple per accepted beat.
// Optional feature macro: IDXGEN_LINEAR_ADDR_EN adds incrementally computed addr_a / addr_b outputs.
module matmul_index_gen #(
    parameter int IW = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [IW-1:0] dim_m,
    input  logic [IW-1:0] dim_n,
    input  logic [IW-1:0] dim_k,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] idx_i,
    output logic [IW-1:0] idx_j,
    output logic [IW-1:0] idx_k,
    output logic          first_k,
    output logic          last_k,
    output logic [IW-1:0] bound_k,
    output logic          busy,
`ifdef IDXGEN_LINEAR_ADDR_EN
    output logic [AW-1:0] addr_a,
    output logic [AW-1:0] addr_b,
`endif
    output logic          done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    if (IW < 1 || AW < 1) begin : g_bad_width
        $error("matmul_index_gen: IW and AW must be at least 1");
    end

    state_t        state_q, state_d;
    logic [IW-1:0] dim_m_q, dim_m_d, dim_n_q, dim_n_d, dim_k_q, dim_k_d;
    logic [IW-1:0] idx_i_q, idx_i_d, idx_j_q, idx_j_d, idx_k_q, idx_k_d;
    logic          out_valid_q, out_valid_d, busy_q, busy_d, done_q, done_d;
    logic          first_k_q, first_k_d, last_k_q, last_k_d;
    logic          k_wrap_s, j_wrap_s, i_wrap_s;
    logic [IW-1:0] k_next_s;
`ifdef IDXGEN_LINEAR_ADDR_EN
    logic [AW-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, row_base_q, row_base_d;
`endif

    assign k_wrap_s = (idx_k_q == dim_k_q - IW'(1));
    assign j_wrap_s = (idx_j_q == dim_n_q - IW'(1));
    assign i_wrap_s = (idx_i_q == dim_m_q - IW'(1));
    assign k_next_s = k_wrap_s ? {IW{1'b0}} : idx_k_q + IW'(1);

    // Next-state and next-output computation for the sweep FSM.
    always_comb begin
        state_d     = state_q;
        dim_m_d     = dim_m_q;
        dim_n_d     = dim_n_q;
        dim_k_d     = dim_k_q;
        idx_i_d     = idx_i_q;
        idx_j_d     = idx_j_q;
        idx_k_d     = idx_k_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        first_k_d   = first_k_q;
        last_k_d    = last_k_q;
`ifdef IDXGEN_LINEAR_ADDR_EN
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        row_base_d  = row_base_q;
`endif
        case (state_q)
            ST_IDLE: begin
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                first_k_d   = 1'b0;
                last_k_d    = 1'b0;
                if (start) begin
                    if (dim_m == '0 || dim_n == '0 || dim_k == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = ST_RUN;
                        dim_m_d     = dim_m;
                        dim_n_d     = dim_n;
                        dim_k_d     = dim_k;
                        idx_i_d     = '0;
                        idx_j_d     = '0;
                        idx_k_d     = '0;
                        out_valid_d = 1'b1;
                        busy_d      = 1'b1;
                        first_k_d   = 1'b1;
                        last_k_d    = (dim_k == IW'(1));
`ifdef IDXGEN_LINEAR_ADDR_EN
                        addr_a_d    = '0;
                        addr_b_d    = '0;
                        row_base_d  = '0;
`endif
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (out_ready) begin
                    idx_k_d   = k_next_s;
                    first_k_d = (k_next_s == '0);
                    last_k_d  = (k_next_s == dim_k_q - IW'(1));
`ifdef IDXGEN_LINEAR_ADDR_EN
                    addr_a_d  = addr_a_q + AW'(1);
                    addr_b_d  = addr_b_q + AW'(dim_n_q);
`endif
                    if (k_wrap_s) begin
                        if (j_wrap_s) begin
                            idx_j_d = '0;
`ifdef IDXGEN_LINEAR_ADDR_EN
                            // New row: i*K advances by K, which is exactly the next linear A address.
                            row_base_d = addr_a_q + AW'(1);
                            addr_b_d   = '0;
`endif
                            if (i_wrap_s) begin
                                state_d     = ST_DONE;
                                out_valid_d = 1'b0;
                                busy_d      = 1'b0;
                                done_d      = 1'b1;
                                first_k_d   = 1'b0;
                                last_k_d    = 1'b0;
                            end else begin
                                idx_i_d = idx_i_q + IW'(1);
                            end
                        end else begin
                            idx_j_d = idx_j_q + IW'(1);
`ifdef IDXGEN_LINEAR_ADDR_EN
                            // Same row, next column: A restarts at the row base, B at column j+1.
                            addr_a_d = row_base_q;
                            addr_b_d = AW'(idx_j_q) + AW'(1);
`endif
                        end
                    end else begin
                        idx_j_d = idx_j_q;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                first_k_d   = 1'b0;
                last_k_d    = 1'b0;
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                first_k_d   = 1'b0;
                last_k_d    = 1'b0;
            end
        endcase
    end

    // State, latched dimensions and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dim_m_q     <= '0;
            dim_n_q     <= '0;
            dim_k_q     <= '0;
            idx_i_q     <= '0;
            idx_j_q     <= '0;
            idx_k_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            first_k_q   <= 1'b0;
            last_k_q    <= 1'b0;
`ifdef IDXGEN_LINEAR_ADDR_EN
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            row_base_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            dim_m_q     <= dim_m_d;
            dim_n_q     <= dim_n_d;
            dim_k_q     <= dim_k_d;
            idx_i_q     <= idx_i_d;
            idx_j_q     <= idx_j_d;
            idx_k_q     <= idx_k_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            first_k_q   <= first_k_d;
            last_k_q    <= last_k_d;
`ifdef IDXGEN_LINEAR_ADDR_EN
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            row_base_q  <= row_base_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign idx_i     = idx_i_q;
    assign idx_j     = idx_j_q;
    assign idx_k     = idx_k_q;
    assign first_k   = first_k_q;
    assign last_k    = last_k_q;
    assign bound_k   = dim_k_q;
`ifdef IDXGEN_LINEAR_ADDR_EN
    assign addr_a    = addr_a_q;
    assign addr_b    = addr_b_q;
`endif

endmodule

// File: tb/tb_matmul_index_gen.sv
// Scoreboard bench for matmul_index_gen: stimulus pushes expected tuples, a negedge monitor pops and compares.
module tb_matmul_index_gen;

    localparam int IW = 32;
    localparam int AW = 32;

    typedef struct {
        int i;
        int j;
        int k;
        bit f;
        bit l;
        int bk;
        int a;
        int b;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, start, out_ready;
    logic [IW-1:0] dim_m, dim_n, dim_k;
    logic          out_valid, first_k, last_k, busy, done;
    logic [IW-1:0] idx_i, idx_j, idx_k, bound_k;
`ifdef IDXGEN_LINEAR_ADDR_EN
    logic [AW-1:0] addr_a, addr_b;
`endif

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   beats_total = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   last_acc_cyc = 0;
    int   valid_cycles = 0;
    int   busy_cycles = 0;
    bit   stalled_prev = 1'b0;
    logic [IW-1:0] held_i, held_j, held_k;

    matmul_index_gen #(.IW(IW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dim_m(dim_m), .dim_n(dim_n), .dim_k(dim_k),
        .out_valid(out_valid), .out_ready(out_ready),
        .idx_i(idx_i), .idx_j(idx_j), .idx_k(idx_k),
        .first_k(first_k), .last_k(last_k), .bound_k(bound_k),
        .busy(busy),
`ifdef IDXGEN_LINEAR_ADDR_EN
        .addr_a(addr_a), .addr_b(addr_b),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: pops the scoreboard on every accepted beat and checks stall stability.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            stalled_prev = 1'b0;
        end else begin
            if (out_valid) valid_cycles++;
            if (busy) busy_cycles++;
            if (busy !== out_valid) check("busy_vs_valid", 64'(busy), 64'(out_valid));
            if (stalled_prev && out_valid) begin
                check("stall_i", 64'(idx_i), 64'(held_i));
                check("stall_j", 64'(idx_j), 64'(held_j));
                check("stall_k", 64'(idx_k), 64'(held_k));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 64'(1), 64'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("idx_i", 64'(idx_i), 64'(e.i));
                    check("idx_j", 64'(idx_j), 64'(e.j));
                    check("idx_k", 64'(idx_k), 64'(e.k));
                    check("first_k", 64'(first_k), 64'(e.f));
                    check("last_k", 64'(last_k), 64'(e.l));
                    check("bound_k", 64'(bound_k), 64'(e.bk));
`ifdef IDXGEN_LINEAR_ADDR_EN
                    check("addr_a", 64'(addr_a), 64'(e.a));
                    check("addr_b", 64'(addr_b), 64'(e.b));
`endif
                end
                beats_total++;
                last_acc_cyc = cyc;
            end
            stalled_prev = out_valid && !out_ready;
            held_i = idx_i;
            held_j = idx_j;
            held_k = idx_k;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (out_valid) check("done_with_valid", 64'(out_valid), 64'(0));
            end
        end
    end

    task automatic push_expect(input int m, input int n, input int k);
        for (int i = 0; i < m; i++)
            for (int j = 0; j < n; j++)
                for (int kk = 0; kk < k; kk++) begin
                    exp_t e;
                    e.i = i; e.j = j; e.k = kk;
                    e.f = (kk == 0); e.l = (kk == k - 1); e.bk = k;
                    e.a = i * k + kk; e.b = kk * n + j;
                    exp_q.push_back(e);
                end
    endtask

    task automatic pulse_start(input int m, input int n, input int k);
        @(posedge clk); #1;
        dim_m = IW'(m); dim_n = IW'(n); dim_k = IW'(k);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // pat 0: out_ready always 1; pat 1: out_ready 1,0,0 repeating, with a stray start and dim changes mid-run.
    task automatic run_sweep(input string name, input int m, input int n, input int k,
                             input int pat, input int exp_beats);
        int b0, d0, cnt;
        b0 = beats_total;
        d0 = done_cnt;
        push_expect(m, n, k);
        pulse_start(m, n, k);
        cnt = 0;
        while (done_cnt == d0 && cnt < 500) begin
            out_ready = (pat == 0) ? 1'b1 : ((cnt % 3) == 0);
            if (pat == 1) begin
                start = (cnt == 4);
                dim_m = IW'(7); dim_n = IW'(1); dim_k = IW'(1);
            end
            cnt++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (cnt >= 500) check({name, "_timeout"}, 64'(1), 64'(0));
        repeat (3) @(posedge clk); #1;
        check({name, "_beats"}, 64'(beats_total - b0), 64'(exp_beats));
        check({name, "_done_count"}, 64'(done_cnt - d0), 64'(1));
        check({name, "_done_latency"}, 64'(done_cyc - last_acc_cyc), 64'(1));
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_valid"}, 64'(out_valid), 64'(0));
        check({name, "_busy"}, 64'(busy), 64'(0));
        check({name, "_done"}, 64'(done), 64'(0));
        check({name, "_first_k"}, 64'(first_k), 64'(0));
        check({name, "_last_k"}, 64'(last_k), 64'(0));
        check({name, "_idx"}, 64'(idx_i | idx_j | idx_k), 64'(0));
        check({name, "_bound_k"}, 64'(bound_k), 64'(0));
    endtask

    initial begin
        int d0, v0, b0, start_cyc, cnt;
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        dim_m = '0; dim_n = '0; dim_k = '0;
        repeat (2) @(posedge clk); #1;
        check_all_zero("reset");
        rst = 1'b0;

        run_sweep("m2n2k2", 2, 2, 2, 0, 8);
        run_sweep("m1n3k1", 1, 3, 1, 0, 3);
        run_sweep("m2n2k3_stall", 2, 2, 3, 1, 12);
        run_sweep("m2n3k2", 2, 3, 2, 0, 12);

        // Zero inner dimension: no tuple, single done pulse right after the start.
        d0 = done_cnt; v0 = valid_cycles; b0 = busy_cycles;
        start_cyc = cyc + 1;
        pulse_start(2, 2, 0);
        repeat (4) @(posedge clk); #1;
        check("zero_dim_done_count", 64'(done_cnt - d0), 64'(1));
        check("zero_dim_done_window", 64'((done_cyc - start_cyc) >= 1 && (done_cyc - start_cyc) <= 2), 64'(1));
        check("zero_dim_no_valid", 64'(valid_cycles - v0), 64'(0));
        check("zero_dim_no_busy", 64'(busy_cycles - b0), 64'(0));

        // Reset after the fifth accepted beat of a 2x2x2 sweep.
        b0 = beats_total;
        push_expect(2, 2, 2);
        pulse_start(2, 2, 2);
        cnt = 0;
        while (beats_total - b0 < 5 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 100) check("rst_mid_timeout", 64'(1), 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b0;
        d0 = done_cnt;
        @(posedge clk); #1;
        check_all_zero("rst_mid");
        rst = 1'b0;
        out_ready = 1'b1;
        exp_q.delete();
        repeat (3) @(posedge clk); #1;
        check("rst_mid_no_done", 64'(done_cnt - d0), 64'(0));

        run_sweep("replay_m2n2k2", 2, 2, 2, 0, 8);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
        $fatal(1, "watchdog");
    end

endmodule
